// File: rtl/traffic_gen_check_pkg.sv
// Shared definitions for the traffic generator/checker: FSM encoding and LFSR polynomial.
package traffic_gen_check_pkg;
   localparam int LFSR_W = 16;
   // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: feedback from bits 0,2,3,5.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_INIT  = 3'd1;
   localparam logic [2:0] ST_SEND  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
   endfunction
endpackage

// File: rtl/traffic_gen_check_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load (load wins over enable).
module lfsr16
   import traffic_gen_check_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RESET_VALUE = 16'hACE1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] state
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= RESET_VALUE;
      else if (load)
         state <= seed;
      else if (enable)
         state <= lfsr_next(state);
   end
endmodule

// File: rtl/traffic_gen_check.sv
// Traffic generator/checker: programs thresholds, pushes an incrementing or LFSR word
// stream into a FIFO device, drains its channels and counts ref/dut output disagreements.
module traffic_gen_check
   import traffic_gen_check_pkg::*;
#(
   parameter int DATA_W     = 6,
   parameter int PTR_L      = 5,
   parameter int N_CH       = 2,
   parameter int N_WORDS    = 50,
   parameter int DRAIN_IDLE = 8,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     mode,
   input  logic [PTR_L-1:0]         umbral_full_cfg,
   input  logic [PTR_L-1:0]         umbral_empty_cfg,
   input  logic                     pause,
   input  logic [N_CH-1:0]          almost_empty,
   input  logic [N_CH*DATA_W-1:0]   data_out_ref,
   input  logic [N_CH*DATA_W-1:0]   data_out_dut,
   output logic                     init,
   output logic                     push_data_in,
   output logic [DATA_W-1:0]        data_in,
   output logic [PTR_L-1:0]         umbral_full,
   output logic [PTR_L-1:0]         umbral_empty,
   output logic [N_CH-1:0]          pop,
   output logic [15:0]              mismatch_cnt,
   output logic                     done,
   output logic                     pass
);
   localparam logic [15:0]       N_WORDS_L    = 16'(N_WORDS);
   localparam logic [7:0]        DRAIN_IDLE_L = 8'(DRAIN_IDLE);
   localparam logic [DATA_W-1:0] FIRST_INC    = DATA_W'(1);

   logic [2:0]        state_reg;
   logic              start_prev_reg, init_phase_reg, mode_reg;
   logic [15:0]       words_sent_reg, words_sent_next, mismatch_next;
   logic [7:0]        idle_cnt_reg, idle_cnt_next;
   logic              start_edge, lfsr_load, lfsr_enable;
   logic [LFSR_W-1:0] lfsr_state, lfsr_after;

   assign start_edge      = start & ~start_prev_reg;
   assign lfsr_load       = start_edge && (state_reg == ST_IDLE || state_reg == ST_DONE);
   // The generator always holds the word currently on data_in; leaving INIT steps past the seed.
   assign lfsr_enable     = (state_reg == ST_INIT && init_phase_reg) ||
                            (state_reg == ST_SEND && push_data_in);
   assign lfsr_after      = lfsr_enable ? lfsr_next(lfsr_state) : lfsr_state;
   assign words_sent_next = words_sent_reg + {15'd0, push_data_in};
   assign idle_cnt_next   = idle_cnt_reg + 8'd1;

   always_comb begin
      mismatch_next = mismatch_cnt;
      if ((state_reg == ST_SEND || state_reg == ST_DRAIN) &&
          data_out_ref != data_out_dut && mismatch_cnt != 16'hFFFF)
         mismatch_next = mismatch_cnt + 16'd1;
   end

   lfsr16 #(.RESET_VALUE(LFSR_SEED)) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .enable (lfsr_enable),
      .load   (lfsr_load),
      .seed   (LFSR_SEED),
      .state  (lfsr_state)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         // A start held high across reset release must not count as a fresh edge.
         start_prev_reg <= 1'b1;
         init_phase_reg <= 1'b0;
         mode_reg       <= 1'b0;
         words_sent_reg <= 16'd0;
         idle_cnt_reg   <= 8'd0;
         init           <= 1'b0;
         push_data_in   <= 1'b0;
         data_in        <= '0;
         umbral_full    <= '0;
         umbral_empty   <= '0;
         pop            <= '0;
         mismatch_cnt   <= 16'd0;
         done           <= 1'b0;
         pass           <= 1'b0;
      end else begin
         start_prev_reg <= start;
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start_edge) begin
                  state_reg      <= ST_INIT;
                  init           <= 1'b1;
                  init_phase_reg <= 1'b0;
                  umbral_full    <= umbral_full_cfg;
                  umbral_empty   <= umbral_empty_cfg;
                  words_sent_reg <= 16'd0;
                  mismatch_cnt   <= 16'd0;
                  mode_reg       <= mode;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  pop            <= '0;
                  push_data_in   <= 1'b0;
               end
            end
            ST_INIT: begin
               if (!init_phase_reg) begin
                  init_phase_reg <= 1'b1;
               end else begin
                  state_reg    <= ST_SEND;
                  init         <= 1'b0;
                  push_data_in <= ~pause;
                  data_in      <= mode_reg ? DATA_W'(lfsr_after) : FIRST_INC;
               end
            end
            ST_SEND: begin
               mismatch_cnt   <= mismatch_next;
               words_sent_reg <= words_sent_next;
               if (push_data_in)
                  data_in <= mode_reg ? DATA_W'(lfsr_after) : data_in + 1'b1;
               if (words_sent_next == N_WORDS_L) begin
                  state_reg    <= ST_DRAIN;
                  push_data_in <= 1'b0;
                  idle_cnt_reg <= 8'd0;
                  pop          <= '0;
               end else begin
                  push_data_in <= ~pause;
               end
            end
            ST_DRAIN: begin
               mismatch_cnt <= mismatch_next;
               if (&almost_empty) begin
                  pop <= '0;
                  if (idle_cnt_next == DRAIN_IDLE_L) begin
                     state_reg <= ST_DONE;
                     done      <= 1'b1;
                     pass      <= (mismatch_next == 16'd0);
                  end else begin
                     idle_cnt_reg <= idle_cnt_next;
                  end
               end else begin
                  idle_cnt_reg <= 8'd0;
                  pop          <= ~almost_empty;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_traffic_gen_check.sv
// Directed bench: two generator instances (50 and 70 words) share stimulus; a scoreboard
// queue per instance holds the expected word stream, checked as each word is pushed.
module tb_traffic_gen_check;
   logic        clk = 1'b0;
   logic        reset, start, mode, pause;
   logic [4:0]  full_cfg, empty_cfg;
   logic [1:0]  almost_empty;
   logic [11:0] ref_d, dut_d;

   logic        init_a, push_a, done_a, pass_a, init_b, push_b, done_b, pass_b;
   logic [5:0]  data_a, data_b;
   logic [4:0]  uf_a, ue_a, uf_b, ue_b;
   logic [1:0]  pop_a, pop_b;
   logic [15:0] mis_a, mis_b;

   int checks = 0;
   int failures = 0;
   int pushes_a, pushes_b, nlog;
   logic [5:0] qa[$];
   logic [5:0] qb[$];
   logic [5:0] log_a[3];

   always #5 clk = ~clk;

   traffic_gen_check #(.N_WORDS(50), .LFSR_SEED(16'hACE1)) dut_a (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .umbral_full_cfg(full_cfg), .umbral_empty_cfg(empty_cfg), .pause(pause),
      .almost_empty(almost_empty), .data_out_ref(ref_d), .data_out_dut(dut_d),
      .init(init_a), .push_data_in(push_a), .data_in(data_a), .umbral_full(uf_a),
      .umbral_empty(ue_a), .pop(pop_a), .mismatch_cnt(mis_a), .done(done_a), .pass(pass_a));

   traffic_gen_check #(.N_WORDS(70), .LFSR_SEED(16'hACE1)) dut_b (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .umbral_full_cfg(full_cfg), .umbral_empty_cfg(empty_cfg), .pause(pause),
      .almost_empty(almost_empty), .data_out_ref(ref_d), .data_out_dut(dut_d),
      .init(init_b), .push_data_in(push_b), .data_in(data_b), .umbral_full(uf_b),
      .umbral_empty(ue_b), .pop(pop_b), .mismatch_cnt(mis_b), .done(done_b), .pass(pass_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumers: one expected word per observed push.
   always @(negedge clk) begin
      if (push_a === 1'b1) begin
         pushes_a++;
         check("a_push_expected", 32'(qa.size() != 0), 32'd1);
         if (qa.size() != 0) check("a_data", 32'(data_a), 32'(qa.pop_front()));
         if (nlog < 3) log_a[nlog] = data_a;
         nlog++;
         $display("push a #%0d data=%0d", pushes_a, data_a);
      end
      if (push_b === 1'b1) begin
         pushes_b++;
         check("b_push_expected", 32'(qb.size() != 0), 32'd1);
         if (qb.size() != 0) check("b_data", 32'(data_b), 32'(qb.pop_front()));
      end
   end

   task automatic start_run(input logic m);
      logic [15:0] s;
      logic [5:0]  w;
      mode = m;
      s = 16'hACE1;
      qa.delete(); qb.delete();
      pushes_a = 0; pushes_b = 0; nlog = 0;
      for (int k = 1; k <= 70; k++) begin
         if (m) begin
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
            w = s[5:0];
         end else begin
            w = 6'(k);
         end
         if (k <= 50) qa.push_back(w);
         qb.push_back(w);
      end
      start = 1'b1;
      tick;
      @(negedge clk);
      check("init_first", 32'(init_a), 32'd1);
      check("umbral_load", 32'({uf_a, ue_a}), 32'({full_cfg, empty_cfg}));
      tick;
      @(negedge clk);
      check("init_second", 32'(init_a), 32'd1);
      start = 1'b0;
      tick;
      @(negedge clk);
      check("init_end", 32'({init_a, push_a}), 32'({1'b0, ~pause}));
   endtask

   task automatic wait_done;
      for (int i = 0; i < 400 && !(done_a && done_b); i++) tick;
      check("done_reached", 32'({done_a, done_b}), 32'd3);
   endtask

   task automatic end_checks(input logic p, input logic [15:0] m);
      @(negedge clk);
      check("a_pushes", 32'(pushes_a), 32'd50);
      check("b_pushes", 32'(pushes_b), 32'd70);
      check("a_status", 32'({done_a, pass_a, mis_a}), 32'({1'b1, p, m}));
      check("b_status", 32'({done_b, pass_b, mis_b}), 32'({1'b1, p, m}));
      $display("run end: mode=%0d pass_a=%0d mis_a=%0d pass_b=%0d mis_b=%0d", mode, pass_a, mis_a, pass_b, mis_b);
   endtask

   initial begin
      logic act;
      reset = 1'b1; start = 1'b0; mode = 1'b0; pause = 1'b0;
      almost_empty = 2'b11; ref_d = '0; dut_d = '0;
      full_cfg = 5'd20; empty_cfg = 5'd3;
      pushes_a = 0; pushes_b = 0; nlog = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl_a", 32'({init_a, push_a, pop_a, done_a, pass_a}), 32'd0);
      check("rst_data_a", 32'({data_a, uf_a, ue_a}), 32'd0);
      check("rst_mis_a", 32'(mis_a), 32'd0);
      check("rst_all_b", 32'({init_b, push_b, pop_b, done_b, pass_b, data_b, uf_b, ue_b}), 32'd0);
      reset = 1'b0;
      tick; tick;

      // Run 1: incrementing pattern, no pause, per-channel drain and idle-count boundary.
      start_run(1'b0);
      full_cfg = 5'd9; empty_cfg = 5'd30;
      for (int i = 0; i < 200 && pushes_a < 50; i++) tick;
      check("a_reach_drain", 32'(pushes_a), 32'd50);
      almost_empty = 2'b01;
      tick;
      almost_empty = 2'b10;
      @(negedge clk);
      check("pop_ch1", 32'(pop_a), 32'd2);
      check("b_no_pop_send", 32'(pop_b), 32'd0);
      tick;
      almost_empty = 2'b11;
      @(negedge clk);
      check("pop_ch0", 32'(pop_a), 32'd1);
      tick;
      @(negedge clk);
      check("pop_idle", 32'(pop_a), 32'd0);
      repeat (6) tick;
      @(negedge clk);
      check("done_not_early", 32'(done_a), 32'd0);
      tick;
      @(negedge clk);
      check("done_at_idle_limit", 32'({done_a, pass_a, mis_a}), 32'({1'b1, 1'b1, 16'd0}));
      check("umbral_hold", 32'({uf_a, ue_a}), 32'({5'd20, 5'd3}));
      wait_done;
      end_checks(1'b1, 16'd0);

      // Run 2: five-cycle pause mid-stream plus an ignored start edge.
      start_run(1'b0);
      repeat (10) tick;
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         @(negedge clk);
         check("pause_push_low", 32'({push_a, push_b}), 32'd0);
         check("pause_data_hold", 32'(data_a), 32'(qa[0]));
      end
      pause = 1'b0;
      tick;
      @(negedge clk);
      check("pause_resume", 32'(push_a), 32'd1);
      start = 1'b1;
      tick;
      start = 1'b0;
      wait_done;
      end_checks(1'b1, 16'd0);

      // Run 3: one output bit disagrees for exactly three cycles.
      start_run(1'b0);
      repeat (10) tick;
      dut_d = 12'h004;
      repeat (3) tick;
      dut_d = '0;
      @(negedge clk);
      check("mismatch_mid", 32'(mis_a), 32'd3);
      wait_done;
      end_checks(1'b0, 16'd3);

      // Run 4: LFSR pattern; first words are the successors of the seed.
      start_run(1'b1);
      wait_done;
      check("lfsr_w0", 32'(log_a[0]), 32'd48);
      check("lfsr_w1", 32'(log_a[1]), 32'd56);
      check("lfsr_w2", 32'(log_a[2]), 32'd28);
      end_checks(1'b1, 16'd0);

      // Run 5: LFSR repeat with random pause, including pause on the last word.
      start_run(1'b1);
      for (int i = 0; i < 1000 && qb.size() > 0; i++) begin
         pause = 1'($urandom_range(0, 1));
         tick;
      end
      pause = 1'b0;
      wait_done;
      end_checks(1'b1, 16'd0);

      // Run 6: reset in the middle of SEND, start held high across release.
      start_run(1'b0);
      repeat (8) tick;
      reset = 1'b1;
      #1;
      check("abort_ctrl_a", 32'({init_a, push_a, pop_a, done_a, pass_a}), 32'd0);
      check("abort_data_a", 32'({data_a, uf_a, ue_a, mis_a}), 32'd0);
      check("abort_b", 32'({push_b, data_b, mis_b}), 32'd0);
      qa.delete(); qb.delete();
      start = 1'b1;
      tick; tick;
      reset = 1'b0;
      act = 1'b0;
      repeat (5) begin
         tick;
         @(negedge clk);
         act = act | init_a | push_a | done_a | init_b | push_b;
      end
      check("idle_after_reset", 32'(act), 32'd0);
      start = 1'b0;
      tick;
      start_run(1'b0);
      wait_done;
      end_checks(1'b1, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/traffic_gen_check.md
TRAFFIC_GEN_CHECK -- requirements
Module: traffic_gen_check

Interface
REQ-001 Parameter DATA_W, default 6: width of data word pushed into the device.
REQ-002 Parameter PTR_L, default 5: width of threshold fields.
REQ-003 Parameter N_CH, default 2: number of device output channels.
REQ-004 Parameter N_WORDS, default 50: words pushed per run, range 1..65535.
REQ-005 Parameter DRAIN_IDLE, default 8: consecutive all-empty cycles ending drain, range 1..255.
REQ-006 Parameter LFSR_SEED, default 16'hACE1: nonzero LFSR start value.
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 start  in  1  level; rising edge launches a run.
REQ-010 mode  in  1  0 = incrementing pattern, 1 = LFSR pattern; sampled at run launch.
REQ-011 umbral_full_cfg / umbral_empty_cfg  in  PTR_L each  threshold values to program.
REQ-012 pause  in  1  device main-FIFO backpressure.
REQ-013 almost_empty  in  N_CH  per-channel output FIFO almost-empty.
REQ-014 data_out_ref / data_out_dut  in  N_CH*DATA_W each  behavioural / synthesised outputs, flattened.
REQ-015 init, push_data_in  out  1 each; data_in  out  DATA_W; umbral_full, umbral_empty  out  PTR_L each; pop  out  N_CH.
REQ-016 mismatch_cnt  out  16; done, pass  out  1 each.

Function
REQ-017 FSM states IDLE, INIT, SEND, DRAIN, DONE; all outputs registered.
REQ-018 IDLE->INIT on start rising edge (start high, previous-cycle start low); start edges in other states ignored.
REQ-019 INIT lasts exactly 2 cycles: init=1, umbral_* loaded from *_cfg, word and mismatch counters cleared, mode latched, LFSR loaded with LFSR_SEED; then ->SEND.
REQ-020 umbral_* hold their value after INIT until next INIT.
REQ-021 SEND: push_data_in next = 1 iff pause==0 and words_sent < N_WORDS; a word counts when push_data_in==1 at a rising edge.
REQ-022 pause high: push_data_in low from the next cycle, data_in held; resume on first cycle pause sampled low.
REQ-023 Incrementing pattern: first word 1, +1 per counted word, wraps modulo 2^DATA_W.
REQ-024 LFSR pattern: 16-bit Fibonacci x^16+x^14+x^13+x^11+1, advances once per counted word; data_in = low DATA_W bits.
REQ-025 words_sent == N_WORDS -> DRAIN, push_data_in 0.
REQ-026 DRAIN: pop[i] next = !almost_empty[i], per channel independently; idle counter increments when all almost_empty high, clears otherwise; reaching DRAIN_IDLE -> DONE, pop all 0.
REQ-027 DONE: done=1, pass = (mismatch_cnt==0); holds until start rising edge, which goes to INIT.
REQ-028 Compare active in SEND and DRAIN: each cycle data_out_ref != data_out_dut increments mismatch_cnt by 1, saturating at 16'hFFFF.
REQ-029 Simultaneous pause and last-word condition: last word not counted until pushed; no extra word ever pushed.

Reset
REQ-030 reset high forces asynchronously: state IDLE, init 0, push_data_in 0, data_in 0, pop 0, umbral_* 0, mismatch_cnt 0, done 0, pass 0, LFSR = LFSR_SEED, counters 0.
REQ-031 reset mid-run aborts; after release block waits in IDLE for a new start rising edge.

Structure
REQ-032 Shared package holds state encoding, LFSR taps, and LFSR width constant.
REQ-033 One sub-module lfsr16 (enable, load, seed, 16-bit state out).

Verification
REQ-034 N_WORDS=50, mode 0, pause 0: push for 50 consecutive cycles, data 1..50 mod 64 (50 wraps nothing; values 1..50), then DRAIN.
REQ-035 mode 0, N_WORDS=70: data_in wraps 63->0; exactly 70 pushes.
REQ-036 pause high 5 cycles mid-SEND: push low 5 cycles, data_in frozen, total pushes still N_WORDS.
REQ-037 ref==dut throughout: done=1, pass=1, mismatch_cnt=0; one output bit forced different 3 cycles: mismatch_cnt=3, pass=0.
REQ-038 mode 1: first three words equal low 6 bits of seed-successor sequence from 16'hACE1; repeat run reproduces identical sequence.
REQ-039 reset asserted during SEND: all outputs 0 immediately; no activity until new start edge.
